// File: rtl/fifo_pkg.sv
// fifo_pkg: shared width helper and read-mode constants for the FIFO slice
package fifo_pkg;
  localparam int FIFO_MODE_STD = 0;
  localparam int FIFO_MODE_FWFT = 1;
  function automatic int logb2(input int n);
    int r;
    r = 0;
    for (int v = n - 1; v > 0; v = v >> 1) r++;
    return r;
  endfunction
endpackage

// File: rtl/fifo_ram.sv
// fifo_ram: DEPTH x WIDTH simple dual-port array with synchronous or asynchronous read
module fifo_ram #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  parameter int AW = 3,
  parameter int SYNC_RD = 1
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_we,
  input  logic [AW-1:0]    i_waddr,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_re,
  input  logic [AW-1:0]    i_raddr,
  output logic [WIDTH-1:0] o_rdata
);
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [WIDTH-1:0] r_q;
  always_ff @(posedge i_clk)
    if (i_we) r_mem[i_waddr] <= i_wdata;
  // read register doubles as the standard-mode output and holds between reads
  always_ff @(posedge i_clk)
    if (i_rst) r_q <= '0;
    else if (i_re) r_q <= r_mem[i_raddr];
  assign o_rdata = SYNC_RD != 0 ? r_q : r_mem[i_raddr];
endmodule

// File: rtl/sync_fifo_ctrl.sv
// sync_fifo_ctrl: single-clock FIFO with full-depth use, FWFT option, level flags,
// flush and overflow/underflow pulses
module sync_fifo_ctrl
  import fifo_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  parameter int FWFT = FIFO_MODE_STD,
  parameter int AFULL_THRESH = DEPTH - 2,
  parameter int AEMPTY_THRESH = 1
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_flush,
  input  logic                    i_wr_enb,
  input  logic [WIDTH-1:0]        i_data_in,
  input  logic                    i_rd_enb,
  output logic [WIDTH-1:0]        o_data_out,
  output logic                    o_valid,
  output logic                    o_empty,
  output logic                    o_full,
  output logic                    o_almost_full,
  output logic                    o_almost_empty,
  output logic [logb2(DEPTH):0]   o_count,
  output logic                    o_overflow,
  output logic                    o_underflow
);
  localparam int AW = logb2(DEPTH);
  localparam int CW = AW + 1;
  logic [AW-1:0]    r_rd_ptr, r_wr_ptr;
  logic [CW-1:0]    r_count;
  logic             r_valid, r_ovf, r_udf;
  logic             w_empty, w_full, w_rd_acc, w_wr_acc;
  logic [WIDTH-1:0] w_rdata;
  assign w_empty  = r_count == '0;
  assign w_full   = r_count == CW'(DEPTH);
  // flush swallows both requests so neither moves state nor raises an error pulse
  assign w_rd_acc = i_rd_enb & ~w_empty & ~i_flush;
  assign w_wr_acc = i_wr_enb & (~w_full | w_rd_acc) & ~i_flush;
  fifo_ram #(
    .WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW),
    .SYNC_RD(FWFT == FIFO_MODE_FWFT ? 0 : 1)
  ) u_ram (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_we   (w_wr_acc),
    .i_waddr(r_wr_ptr),
    .i_wdata(i_data_in),
    .i_re   (w_rd_acc),
    .i_raddr(r_rd_ptr),
    .o_rdata(w_rdata)
  );
  always_ff @(posedge i_clk)
    if (i_rst || i_flush) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
      r_valid  <= 1'b0;
      r_ovf    <= 1'b0;
      r_udf    <= 1'b0;
    end else begin
      r_rd_ptr <= w_rd_acc ? r_rd_ptr + AW'(1) : r_rd_ptr;
      r_wr_ptr <= w_wr_acc ? r_wr_ptr + AW'(1) : r_wr_ptr;
      r_count  <= r_count + CW'(w_wr_acc) - CW'(w_rd_acc);
      r_valid  <= w_rd_acc;
      r_ovf    <= i_wr_enb & ~w_wr_acc;
      r_udf    <= i_rd_enb & w_empty;
    end
  assign o_data_out     = FWFT == FIFO_MODE_FWFT ? (w_empty ? '0 : w_rdata) : w_rdata;
  assign o_valid        = FWFT == FIFO_MODE_FWFT ? ~w_empty : r_valid;
  assign o_empty        = w_empty;
  assign o_full         = w_full;
  assign o_almost_full  = int'(r_count) >= AFULL_THRESH;
  assign o_almost_empty = int'(r_count) <= AEMPTY_THRESH;
  assign o_count        = r_count;
  assign o_overflow     = r_ovf;
  assign o_underflow    = r_udf;
endmodule

// File: doc/sync_fifo_ctrl.md
# sync_fifo_ctrl

Parametrised synchronous FIFO for cache-side and pipeline buffering: a refill, write-back or request queue between a producer and a consumer on the same clock. It adds several capabilities to the plain FIFO: all DEPTH entries usable, full-with-read write acceptance, selectable standard or first-word-fall-through (FWFT) read mode, programmable almost-full/almost-empty flags, an occupancy count, flush, and overflow/underflow pulses.

## Interface
- WIDTH, 8: data word width in bits.
- DEPTH, 8: number of entries; power of two, ≥ 2.
- FWFT, 0: 0 = standard mode (read data one cycle after RD_ENB); 1 = first-word-fall-through.
- AFULL_THRESH, DEPTH-2: ALMOST_FULL asserts when COUNT ≥ this value.
- AEMPTY_THRESH, 1: ALMOST_EMPTY asserts when COUNT ≤ this value.
- CLK  in  1  clock; all logic on the rising edge.
- RST  in  1  reset; synchronous, active-high.
- FLUSH  in  1  synchronous clear of contents.
- WR_ENB  in  1  write request.
- DATA_IN  in  WIDTH  write data.
- RD_ENB  in  1  read request (standard mode) or pop/acknowledge (FWFT mode).
- DATA_OUT  out  WIDTH  read data.
- VALID  out  1  DATA_OUT holds a word read this transaction.
- EMPTY  out  1  COUNT == 0.
- FULL  out  1  COUNT == DEPTH.
- ALMOST_FULL  out  1  COUNT ≥ AFULL_THRESH.
- ALMOST_EMPTY  out  1  COUNT ≤ AEMPTY_THRESH.
- COUNT  out  log2(DEPTH)+1  occupancy, 0..DEPTH.
- OVERFLOW  out  1  one-cycle pulse: a write was dropped.
- UNDERFLOW  out  1  one-cycle pulse: a read was dropped.

## Operation
- Acceptance rules:
  - rd_acc = RD_ENB & !EMPTY.
  - wr_acc = WR_ENB & (!FULL | rd_acc). A write while full is accepted if a read is accepted in the same cycle.
  - When empty with both requests, the read is rejected and the write is accepted.
- Pointers: rd_ptr and wr_ptr are log2(DEPTH) bits and wrap naturally.
- COUNT: +1 on wr_acc only, −1 on rd_acc only, unchanged on both or neither.
- Standard mode:
  - rd_acc registers mem[rd_ptr] into DATA_OUT; VALID is 1 for the following cycle only.
  - DATA_OUT holds its value when there is no rd_acc.
- FWFT mode:
  - DATA_OUT = mem[rd_ptr] when !EMPTY, else 0. VALID = !EMPTY.
  - rd_acc pops the head, and the next word appears the following cycle.
- OVERFLOW is registered: 1 in the cycle after WR_ENB & !wr_acc. UNDERFLOW is registered: 1 in the cycle after RD_ENB & EMPTY.
- FLUSH:
  - Clears pointers, COUNT, VALID, OVERFLOW and UNDERFLOW next edge.
  - Overrides WR_ENB/RD_ENB in the same cycle; both are dropped without OVERFLOW/UNDERFLOW pulses.
  - In standard mode, DATA_OUT retains its value.
- RST:
  - Has priority over FLUSH.
  - Reset values: DATA_OUT = 0, VALID = 0, COUNT = 0, EMPTY = 1, FULL = 0, ALMOST_EMPTY = 1, ALMOST_FULL = 0 (given AFULL_THRESH > 0), OVERFLOW = 0, UNDERFLOW = 0.
  - Memory contents are not cleared.
- Reset or flush mid-burst discards all stored words; there is no partial completion.

## Timing
- Write-to-visible latency:
  - FWFT: a word written at edge n is on DATA_OUT with VALID at cycle n+1 if the FIFO was empty.
  - Standard: a read can be issued in cycle n+1, and the data is valid in cycle n+2.
- Status flags (EMPTY, FULL, ALMOST_*, COUNT) are all derived from registered COUNT. They update the cycle after the accepting edge, with no combinational path from WR_ENB/RD_ENB.
- Sustained throughput: one write and one read per cycle, including at full and at wrap-around.
- Single clock domain; no CDC.

## Structure
- Shared package fifo_pkg:
  - logb2 width function.
  - Mode constants FIFO_MODE_STD = 0 and FIFO_MODE_FWFT = 1.
- Sub-module fifo_ram:
  - DEPTH×WIDTH simple dual-port array, one write port and one read port.
  - Read is synchronous for standard mode and asynchronous for FWFT, selected by parameter.
- Top-level logic: pointers, count, flags, error pulses, flush/reset.

## Test plan
All scenarios use WIDTH=8, DEPTH=8.
- Fill, standard mode, AFULL_THRESH=6:
  - After RST, write 0x10..0x17 on consecutive cycles -> ALMOST_FULL after the 6th write, FULL and COUNT=8 after the 8th.
  - A 9th write with 0x99 -> OVERFLOW=1 for one cycle, COUNT stays 8.
- Drain, standard mode:
  - Read 8 times -> DATA_OUT = 0x10..0x17, each one cycle after its RD_ENB with VALID=1; then EMPTY=1.
  - An extra read -> UNDERFLOW pulse, DATA_OUT holds 0x17, VALID=0.
- Full with simultaneous read/write:
  - With FIFO full of 0x10..0x17, assert WR_ENB=1 with 0x20 and RD_ENB=1 -> COUNT stays 8, no OVERFLOW.
  - Subsequent drain returns 0x11..0x17 then 0x20.
- Wrap-around:
  - 40 cycles of random interleaved writes/reads keeping COUNT within 0..8 -> output order matches the scoreboard, and COUNT matches the model every cycle.
- FWFT=1:
  - Write 0xA5 into an empty FIFO at edge n -> DATA_OUT=0xA5 and VALID=1 at cycle n+1 with no RD_ENB.
  - RD_ENB at n+1 -> EMPTY=1 and DATA_OUT=0 at n+2.
- Flush and reset:
  - With 5 words stored, FLUSH=1 together with WR_ENB=1 -> next cycle COUNT=0, EMPTY=1, no OVERFLOW, and the word is dropped.
  - RST asserted mid-burst -> all outputs at their reset values next cycle.
